// File: rtl/led_chaser_pkg.sv
// Shared types for the chasing-LED engine: motion modes and direction encoding.
// Optional LED_CHASER_TRAIL_EN build adds a trailing LED (see led_chaser.sv).
package led_chaser_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP_L = 2'b00,
    MODE_WRAP_R = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_FILL   = 2'b11
  } mode_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/tick_prescaler.sv
// Base-tick prescaler plus step counter; emits a one-cycle step strobe.
// Unaffected by the LED_CHASER_TRAIL_EN build option.
module tick_prescaler
  import led_chaser_pkg::*;
#(
  parameter int BASE_DIV = 1_000_000,
  parameter int SPEED_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stop,
  input  logic [SPEED_W-1:0] speed,
  output logic               step
);

  localparam int BW = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
  localparam logic [BW-1:0] BASE_LAST = BW'(BASE_DIV - 1);

  logic [BW-1:0]      base_cnt_q, base_cnt_d;
  logic [SPEED_W-1:0] step_cnt_q, step_cnt_d;
  logic               base_tick;

  always_comb begin
    // stop masks the tick so a frozen prescaler can never fire a step
    base_tick  = !stop && (base_cnt_q == BASE_LAST);
    step       = base_tick && (step_cnt_q >= speed);
    base_cnt_d = base_cnt_q;
    step_cnt_d = step_cnt_q;
    if (!stop) begin
      base_cnt_d = base_tick ? '0 : base_cnt_q + 1'b1;
    end
    if (step) begin
      step_cnt_d = '0;
    end else if (base_tick) begin
      step_cnt_d = step_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_cnt_q <= '0;
      step_cnt_q <= '0;
    end else begin
      base_cnt_q <= base_cnt_d;
      step_cnt_q <= step_cnt_d;
    end
  end

endmodule

// File: rtl/led_chaser.sv
// Chasing-LED engine: position/direction state, mode latch and LED decode.
// Define LED_CHASER_TRAIL_EN to add a pos_prev register and a two-LED comet.
module led_chaser
  import led_chaser_pkg::*;
#(
  parameter int N_LEDS   = 16,
  parameter int BASE_DIV = 1_000_000,
  parameter int SPEED_W  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stop,
  input  logic [SPEED_W-1:0]        speed,
  input  mode_e                     mode,
  output logic [N_LEDS-1:0]         led,
  output logic [$clog2(N_LEDS)-1:0] pos,
  output logic                      step_pulse
);

  localparam int PW = $clog2(N_LEDS);
  localparam logic [PW-1:0] LAST = PW'(N_LEDS - 1);

  logic          step;
  logic [PW-1:0] pos_q, pos_d;
  logic          dir_q, dir_d;
  mode_e         mode_q, mode_d;
  logic          step_pulse_q, step_pulse_d;

  tick_prescaler #(
    .BASE_DIV (BASE_DIV),
    .SPEED_W  (SPEED_W)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .stop  (stop),
    .speed (speed),
    .step  (step)
  );

  // The freshly sampled mode governs this very step's motion.
  always_comb begin
    pos_d        = pos_q;
    dir_d        = dir_q;
    mode_d       = mode_q;
    step_pulse_d = step;
    if (step) begin
      mode_d = mode;
      case (mode)
        MODE_WRAP_R: pos_d = (pos_q == '0) ? LAST : pos_q - 1'b1;
        MODE_BOUNCE: begin
          if (pos_q == LAST) begin
            dir_d = DIR_DOWN;
            pos_d = pos_q - 1'b1;
          end else if (pos_q == '0) begin
            dir_d = DIR_UP;
            pos_d = pos_q + 1'b1;
          end else if (dir_q == DIR_UP) begin
            pos_d = pos_q + 1'b1;
          end else begin
            pos_d = pos_q - 1'b1;
          end
        end
        default:     pos_d = (pos_q == LAST) ? '0 : pos_q + 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_q        <= '0;
      dir_q        <= DIR_UP;
      mode_q       <= MODE_WRAP_L;
      step_pulse_q <= 1'b0;
    end else begin
      pos_q        <= pos_d;
      dir_q        <= dir_d;
      mode_q       <= mode_d;
      step_pulse_q <= step_pulse_d;
    end
  end

`ifdef LED_CHASER_TRAIL_EN
  logic [PW-1:0] pos_prev_q, pos_prev_d;

  always_comb begin
    pos_prev_d = step ? pos_q : pos_prev_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_prev_q <= '0;
    end else begin
      pos_prev_q <= pos_prev_d;
    end
  end

  for (genvar gi = 0; gi < N_LEDS; gi++) begin : g_led
    assign led[gi] = (mode_q == MODE_FILL) ? (PW'(gi) <= pos_q)
                   : ((PW'(gi) == pos_q) || (PW'(gi) == pos_prev_q));
  end
`else
  for (genvar gi = 0; gi < N_LEDS; gi++) begin : g_led
    assign led[gi] = (mode_q == MODE_FILL) ? (PW'(gi) <= pos_q)
                   : (PW'(gi) == pos_q);
  end
`endif

  assign pos        = pos_q;
  assign step_pulse = step_pulse_q;

endmodule
